// File: rtl/cmd_byte_framer.sv
// Frames UART byte pairs into 16-bit commands and serialises one-byte responses
// back out through the UART transmitter, with an inter-byte resync timeout.
//
// state    | meaning
// WAIT_HI  | idle, next byte is a command high byte
// WAIT_LO  | high byte held, timing out the low byte
// HOLD     | command valid, waiting for the processor to consume it
// TX_IDLE  | transmitter free
// TX_BUSY  | byte in flight, one further response may be pending
module cmd_byte_framer #(
  parameter int TO_CLKS = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        overrun,
  output logic        frm_err,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        resp_sent
);

  typedef enum logic [1:0] {WAIT_HI, WAIT_LO, HOLD} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  localparam logic [19:0] TO_LAST = 20'(TO_CLKS - 1);
  localparam logic [19:0] CNT_MAX = '1;

  rx_state_t   rx_state, rx_state_nxt;
  logic [19:0] to_cnt, to_cnt_nxt;
  logic [15:0] cmd_nxt;
  logic        cmd_rdy_nxt, overrun_nxt, frm_err_nxt;

  tx_state_t   tx_state, tx_state_nxt;
  logic        pend_vld, pend_vld_nxt;
  logic [7:0]  pend, pend_nxt, tx_data_nxt;
  logic        trmt_nxt, resp_sent_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= WAIT_HI;
      to_cnt    <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      overrun   <= 1'b0;
      frm_err   <= 1'b0;
      tx_state  <= TX_IDLE;
      pend_vld  <= 1'b0;
      pend      <= '0;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      rx_state  <= rx_state_nxt;
      to_cnt    <= to_cnt_nxt;
      cmd       <= cmd_nxt;
      cmd_rdy   <= cmd_rdy_nxt;
      overrun   <= overrun_nxt;
      frm_err   <= frm_err_nxt;
      tx_state  <= tx_state_nxt;
      pend_vld  <= pend_vld_nxt;
      pend      <= pend_nxt;
      tx_data   <= tx_data_nxt;
      trmt      <= trmt_nxt;
      resp_sent <= resp_sent_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    to_cnt_nxt   = to_cnt;
    cmd_nxt      = cmd;
    cmd_rdy_nxt  = cmd_rdy;
    overrun_nxt  = overrun;
    frm_err_nxt  = 1'b0;
    case (rx_state)
      WAIT_HI: begin
        if (rx_rdy) begin
          cmd_nxt[15:8] = rx_data;
          to_cnt_nxt    = '0;
          rx_state_nxt  = WAIT_LO;
        end
      end
      WAIT_LO: begin
        to_cnt_nxt = (to_cnt == CNT_MAX) ? to_cnt : to_cnt + 20'd1;
        // A byte arriving on the timeout cycle still completes the frame
        if (rx_rdy) begin
          cmd_nxt[7:0] = rx_data;
          cmd_rdy_nxt  = 1'b1;
          rx_state_nxt = HOLD;
        end else if (to_cnt == TO_LAST) begin
          frm_err_nxt  = 1'b1;
          rx_state_nxt = WAIT_HI;
        end
      end
      HOLD: begin
        if (clr_cmd_rdy) begin
          cmd_rdy_nxt = 1'b0;
          overrun_nxt = 1'b0;
          if (rx_rdy) begin
            cmd_nxt[15:8] = rx_data;
            to_cnt_nxt    = '0;
            rx_state_nxt  = WAIT_LO;
          end else begin
            rx_state_nxt = WAIT_HI;
          end
        end else if (rx_rdy) begin
          overrun_nxt = 1'b1;
        end
      end
      default: rx_state_nxt = WAIT_HI;
    endcase
  end

  always_comb begin
    tx_state_nxt  = tx_state;
    pend_vld_nxt  = pend_vld;
    pend_nxt      = pend;
    tx_data_nxt   = tx_data;
    trmt_nxt      = 1'b0;
    resp_sent_nxt = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_nxt  = resp;
          trmt_nxt     = 1'b1;
          tx_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_sent_nxt = 1'b1;
          // Pending byte drains first; a same-cycle request refills the slot
          if (pend_vld) begin
            tx_data_nxt  = pend;
            trmt_nxt     = 1'b1;
            pend_vld_nxt = send_resp;
            if (send_resp) pend_nxt = resp;
          end else if (send_resp) begin
            tx_data_nxt = resp;
            trmt_nxt    = 1'b1;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end else if (send_resp) begin
          pend_nxt     = resp;
          pend_vld_nxt = 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmd_byte_framer.sv
// Bench for cmd_byte_framer: directed scenarios with fixed expectations, then
// randomized traffic against an event-level reference model.
module tb_cmd_byte_framer;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy, overrun, frm_err;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        tx_done = 1'b0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        resp_sent;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [15:0] m_cmd;
  logic        m_rdy, m_ovr, m_ferr, m_have_hi;
  int          m_age;
  logic        m_busy, m_trmt, m_rsent;
  logic [7:0]  m_txd;
  logic [7:0]  m_pendq[$];

  always #5 clk = ~clk;

  cmd_byte_framer #(.TO_CLKS(TO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .overrun(overrun), .frm_err(frm_err), .send_resp(send_resp),
    .resp(resp), .tx_done(tx_done), .trmt(trmt), .tx_data(tx_data),
    .resp_sent(resp_sent)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b; tick(); rx_rdy = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_resp = 1'b1; resp = b; tick(); send_resp = 1'b0;
  endtask

  task automatic done_pulse();
    tx_done = 1'b1; tick(); tx_done = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic test_reset();
    logic [28:0] outs;
    #2 rst = 1'b1;
    #1 outs = {cmd, cmd_rdy, overrun, frm_err, trmt, tx_data, resp_sent};
    n_total++; if (outs !== 29'h0) $display("FAIL reset_async: outputs=%h want 0", outs); else n_pass++;
    tick(); rst = 1'b0; tick();
    outs = {cmd, cmd_rdy, overrun, frm_err, trmt, tx_data, resp_sent};
    n_total++; if (outs !== 29'h0) $display("FAIL reset_release: outputs=%h want 0", outs); else n_pass++;
  endtask

  task automatic test_basic_cmd();
    rx_byte(8'h70);
    repeat (99) tick();
    n_total++; if (cmd_rdy !== 1'b0) $display("FAIL basic_early_rdy: cmd_rdy=%b want 0", cmd_rdy); else n_pass++;
    rx_byte(8'h00);
    n_total++; if (cmd !== 16'h7000) $display("FAIL basic_cmd: cmd=%h want 7000", cmd); else n_pass++;
    n_total++; if (cmd_rdy !== 1'b1) $display("FAIL basic_rdy: cmd_rdy=%b want 1", cmd_rdy); else n_pass++;
    repeat (20) tick();
    n_total++; if (cmd_rdy !== 1'b1) $display("FAIL basic_hold: cmd_rdy=%b want 1", cmd_rdy); else n_pass++;
    clr_pulse();
    n_total++; if (cmd_rdy !== 1'b0) $display("FAIL basic_clr: cmd_rdy=%b want 0", cmd_rdy); else n_pass++;
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int at = -1;
    logic rdy_seen = 1'b0;
    rx_byte(8'h24);
    for (int i = 1; i <= TO + 4; i++) begin
      tick();
      if (frm_err) begin pulses++; at = i; end
      if (cmd_rdy) rdy_seen = 1'b1;
    end
    n_total++; if (pulses != 1) $display("FAIL timeout_pulses: count=%0d want 1", pulses); else n_pass++;
    n_total++; if (at != TO) $display("FAIL timeout_cycle: at=%0d want %0d", at, TO); else n_pass++;
    n_total++; if (rdy_seen !== 1'b0) $display("FAIL timeout_rdy: cmd_rdy seen=%b want 0", rdy_seen); else n_pass++;
    rx_byte(8'h01); rx_byte(8'h34);
    n_total++; if ({cmd_rdy, cmd} !== {1'b1, 16'h0134}) $display("FAIL timeout_resync: rdy,cmd=%b,%h want 1,0134", cmd_rdy, cmd); else n_pass++;
    clr_pulse();
    // low byte on the last allowed cycle still completes the frame
    rx_byte(8'hAB);
    repeat (TO - 1) tick();
    rx_byte(8'hCD);
    n_total++; if ({cmd_rdy, frm_err, cmd} !== {2'b10, 16'hABCD}) $display("FAIL timeout_byte_wins: rdy,ferr,cmd=%b,%b,%h want 1,0,abcd", cmd_rdy, frm_err, cmd); else n_pass++;
    clr_pulse();
    // one cycle later the high byte is discarded
    rx_byte(8'hEE);
    repeat (TO) tick();
    n_total++; if (frm_err !== 1'b1) $display("FAIL timeout_edge: frm_err=%b want 1", frm_err); else n_pass++;
    rx_byte(8'h77); rx_byte(8'h88);
    n_total++; if ({cmd_rdy, cmd} !== {1'b1, 16'h7788}) $display("FAIL timeout_after_edge: rdy,cmd=%b,%h want 1,7788", cmd_rdy, cmd); else n_pass++;
    clr_pulse();
  endtask

  task automatic test_overrun();
    rx_byte(8'h12);
    clr_pulse();
    rx_byte(8'h34);
    n_total++; if ({cmd_rdy, cmd} !== {1'b1, 16'h1234}) $display("FAIL clr_outside_hold: rdy,cmd=%b,%h want 1,1234", cmd_rdy, cmd); else n_pass++;
    rx_byte(8'h56);
    n_total++; if ({overrun, cmd_rdy, cmd} !== {2'b11, 16'h1234}) $display("FAIL overrun_set: ovr,rdy,cmd=%b,%b,%h want 1,1,1234", overrun, cmd_rdy, cmd); else n_pass++;
    repeat (3) tick();
    n_total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: overrun=%b want 1", overrun); else n_pass++;
    clr_pulse();
    n_total++; if ({cmd_rdy, overrun} !== 2'b00) $display("FAIL overrun_clr: rdy,ovr=%b,%b want 0,0", cmd_rdy, overrun); else n_pass++;
  endtask

  task automatic test_clr_with_rx();
    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h99);
    rx_rdy = 1'b1; rx_data = 8'h40; clr_cmd_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    n_total++; if ({cmd_rdy, overrun} !== 2'b00) $display("FAIL clr_rx_clear: rdy,ovr=%b,%b want 0,0", cmd_rdy, overrun); else n_pass++;
    rx_byte(8'h00);
    n_total++; if ({cmd_rdy, overrun, cmd} !== {2'b10, 16'h4000}) $display("FAIL clr_rx_frame: rdy,ovr,cmd=%b,%b,%h want 1,0,4000", cmd_rdy, overrun, cmd); else n_pass++;
    clr_pulse();
  endtask

  task automatic test_resp();
    send(8'hA5);
    n_total++; if ({trmt, tx_data} !== {1'b1, 8'hA5}) $display("FAIL resp_first: trmt,data=%b,%h want 1,a5", trmt, tx_data); else n_pass++;
    send(8'h5A);
    n_total++; if ({trmt, tx_data} !== {1'b0, 8'hA5}) $display("FAIL resp_busy_hold: trmt,data=%b,%h want 0,a5", trmt, tx_data); else n_pass++;
    send(8'hA5);
    repeat (2) tick();
    done_pulse();
    n_total++; if ({resp_sent, trmt, tx_data} !== {2'b11, 8'hA5}) $display("FAIL resp_pending: sent,trmt,data=%b,%b,%h want 1,1,a5", resp_sent, trmt, tx_data); else n_pass++;
    tick();
    n_total++; if ({resp_sent, trmt} !== 2'b00) $display("FAIL resp_pulse_width: sent,trmt=%b,%b want 0,0", resp_sent, trmt); else n_pass++;
    done_pulse();
    n_total++; if ({resp_sent, trmt} !== 2'b10) $display("FAIL resp_last_done: sent,trmt=%b,%b want 1,0", resp_sent, trmt); else n_pass++;
    tick();
    done_pulse();
    n_total++; if ({resp_sent, trmt} !== 2'b00) $display("FAIL resp_idle_done: sent,trmt=%b,%b want 0,0", resp_sent, trmt); else n_pass++;
    send(8'h3C);
    tick();
    tx_done = 1'b1; send_resp = 1'b1; resp = 8'hC3;
    tick();
    tx_done = 1'b0; send_resp = 1'b0;
    n_total++; if ({resp_sent, trmt, tx_data} !== {2'b11, 8'hC3}) $display("FAIL resp_direct: sent,trmt,data=%b,%b,%h want 1,1,c3", resp_sent, trmt, tx_data); else n_pass++;
    done_pulse();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [28:0] outs;
    rx_byte(8'h70);
    send(8'h11);
    send(8'h22);
    rst = 1'b1;
    #1 outs = {cmd, cmd_rdy, overrun, frm_err, trmt, tx_data, resp_sent};
    n_total++; if (outs !== 29'h0) $display("FAIL reset_mid: outputs=%h want 0", outs); else n_pass++;
    #2 rst = 1'b0;
    tick();
    done_pulse();
    n_total++; if ({resp_sent, trmt} !== 2'b00) $display("FAIL reset_pend_drop: sent,trmt=%b,%b want 0,0", resp_sent, trmt); else n_pass++;
    rx_byte(8'h12); rx_byte(8'h34);
    n_total++; if ({cmd_rdy, cmd} !== {1'b1, 16'h1234}) $display("FAIL reset_reframe: rdy,cmd=%b,%h want 1,1234", cmd_rdy, cmd); else n_pass++;
    clr_pulse();
  endtask

  task automatic test_random();
    int ucnt = 0;
    int len, mode;
    logic [7:0] b;
    logic handled;
    apply_reset();
    m_cmd = 16'h0; m_rdy = 0; m_ovr = 0; m_ferr = 0; m_have_hi = 0; m_age = 0;
    m_busy = 0; m_trmt = 0; m_rsent = 0; m_txd = 8'h00; m_pendq.delete();
    for (int seg = 0; seg < 14; seg++) begin
      len  = $urandom_range(200, 1400);
      mode = (seg == 0) ? 0 : $urandom_range(0, 2);
      for (int c = 0; c < len; c++) begin
        b = 8'($urandom);
        rx_data = b;
        rx_rdy = (mode == 2) ? ($urandom_range(0, 3) == 0) :
                 (mode == 1) ? ($urandom_range(0, 59) == 0) : 1'b0;
        if (seg == 0 && c == 0) rx_rdy = 1'b1;
        clr_cmd_rdy = ($urandom_range(0, 15) == 0);
        send_resp = ($urandom_range(0, 4) == 0);
        resp = 8'($urandom);
        tx_done = 1'b0;
        if (ucnt > 0) begin
          ucnt--;
          if (ucnt == 0) tx_done = 1'b1;
        end
        // receive model: frames, holding, timeout measured from the high-byte edge
        m_ferr = 1'b0;
        if (m_rdy) begin
          if (clr_cmd_rdy) begin
            m_rdy = 1'b0; m_ovr = 1'b0;
            if (rx_rdy) begin m_cmd[15:8] = b; m_have_hi = 1'b1; m_age = 0; end
          end else if (rx_rdy) m_ovr = 1'b1;
        end else if (m_have_hi) begin
          m_age++;
          if (rx_rdy) begin m_cmd[7:0] = b; m_rdy = 1'b1; m_have_hi = 1'b0; end
          else if (m_age == TO) begin m_ferr = 1'b1; m_have_hi = 1'b0; end
        end else if (rx_rdy) begin
          m_cmd[15:8] = b; m_have_hi = 1'b1; m_age = 0;
        end
        // transmit model: one in flight, one-deep last-wins backlog
        m_trmt = 1'b0; m_rsent = 1'b0; handled = 1'b0;
        if (!m_busy) begin
          if (send_resp) begin m_txd = resp; m_trmt = 1'b1; m_busy = 1'b1; handled = 1'b1; end
        end else if (tx_done) begin
          m_rsent = 1'b1;
          if (m_pendq.size() > 0) begin m_txd = m_pendq.pop_front(); m_trmt = 1'b1; end
          else if (send_resp) begin m_txd = resp; m_trmt = 1'b1; handled = 1'b1; end
          else m_busy = 1'b0;
        end
        if (m_busy && send_resp && !handled) begin m_pendq.delete(); m_pendq.push_back(resp); end
        tick();
        n_total++;
        if ({cmd, cmd_rdy, overrun, frm_err} !== {m_cmd, m_rdy, m_ovr, m_ferr})
          $display("FAIL rand_rx @%0t: cmd,rdy,ovr,ferr=%h,%b,%b,%b want %h,%b,%b,%b", $time,
                   cmd, cmd_rdy, overrun, frm_err, m_cmd, m_rdy, m_ovr, m_ferr);
        else n_pass++;
        n_total++;
        if ({trmt, tx_data, resp_sent} !== {m_trmt, m_txd, m_rsent})
          $display("FAIL rand_tx @%0t: trmt,data,sent=%b,%h,%b want %b,%h,%b", $time,
                   trmt, tx_data, resp_sent, m_trmt, m_txd, m_rsent);
        else n_pass++;
        if (trmt) ucnt = $urandom_range(1, 6);
      end
    end
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0; tx_done = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_cmd();
    test_timeout();
    test_overrun();
    test_clr_with_rx();
    test_resp();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
